sram_port0_ctrl: RTL and testbench
==================================

Name: sram_port0_ctrl

Overview:
- Request front-end that drives the RW port (port 0) of the 32x256 1RW1R OpenRAM macro.
- Accepts byte-addressed read/write requests with byte/half/word size over a valid/ready channel.
- Converts each request into registered macro pin values: csb0, web0, wmask0, addr0, din0.
- Captures dout0 at the correct edge, lane-extracts the data, and returns in-order responses through a backpressured response FIFO.

Parameters:
- ADDR_WIDTH, 8, word-address width of the macro.
- DATA_WIDTH, 32, macro word width. Fixed at 32; the lane logic assumes 4 bytes.
- NUM_WMASKS, 4, number of byte write-mask bits.
- RESP_DEPTH, 4, response credit limit, covering in-flight accesses plus FIFO entries. Minimum legal value is 3.

Ports:
- clk  in  1  single clock; also drives macro clk0
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid&&req_ready at posedge clk
- req_we  in  1  1=write, 0=read
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  write data, right-justified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_rdata  out  32  read data, zero-extended; 0 for writes and errors
- rsp_err  out  1  misaligned or illegal-size request
- sram_csb0  out  1  macro chip select, active low
- sram_web0  out  1  macro write enable, active low
- sram_wmask0  out  NUM_WMASKS  macro byte write mask
- sram_addr0  out  ADDR_WIDTH  macro word address, equal to req_addr[ADDR_WIDTH+1:2]
- sram_din0  out  32  macro write data, lane-shifted
- sram_dout0  in  32  macro read data

Behaviour:
- Reset (async, rst_n=0):
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Pipeline stages and FIFO are cleared.
  - Reset mid-operation drops all pending responses; no macro access is issued after reset asserts.
- Credit and req_ready:
  - inflight = s1_valid + s2_valid + fifo_count, all from registers.
  - req_ready = (inflight < RESP_DEPTH).
  - A same-cycle FIFO pop is not credited.
- Stage 1 (accept edge E0): macro pins are registered from the request and held for exactly one cycle.
  - Read: csb0=0, web0=1, wmask0=0.
  - Write: csb0=0, web0=0.
    - wmask0: byte → 1<<addr[1:0]; half → 2'b11<<{addr[1],1'b0}; word → 4'hF.
    - din0: wdata[7:0] or wdata[15:0] replicated across lanes; word passes through unchanged.
  - Error (half with addr[0]=1; word with addr[1:0]!=0; size=3): csb0 stays 1. The entry still flows through the pipeline with err=1.
  - No accept at E0: csb0=1, web0=1, wmask0=0.
  - addr0 and din0 may hold their last values while idle.
- Stage 2 (E1): the macro latches its inputs; dout0 becomes valid after the following negedge.
- Capture (E2): the stage-2 entry is pushed into the FIFO.
  - Reads latch sram_dout0 lane-extracted:
    - byte: dout0[8*addr[1:0]+:8], zero-extended;
    - half: dout0[16*addr[1]+:16], zero-extended;
    - word: dout0 unchanged.
  - Writes and errors push rdata=0. dout0 is never sampled for them because it is X.
- Latency: rsp_valid rises in the cycle after E2, i.e. two cycles after the accept cycle, when the FIFO is empty.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Ordering: responses are strictly in request order, with errors interleaved in place.
- FIFO: depth RESP_DEPTH, rsp_* driven from the head register.
  - Push and pop in the same cycle at any occupancy is legal.
  - Overflow cannot occur because of the credit rule; a push when full is an assertion failure.
- Read-after-write to the same address, back to back, returns the new data. The macro writes on the negedge of E1 and the read latches at E1's successor, so no forwarding is needed.
- rsp_ready=0 indefinitely: the pipeline drains into the FIFO and req_ready falls once inflight reaches RESP_DEPTH.

Test Plan:
- Word write 0xDEADBEEF to addr 0x010, then word read 0x010:
  - write cycle shows csb0=0, web0=0, wmask0=4'hF, addr0=0x04;
  - read returns rsp_rdata=0xDEADBEEF with err=0, rsp_valid two cycles after accept.
- Byte write 0xA5 to 0x013, then word read 0x010 → wmask0=4'b1000, din0=0xA5A5A5A5, read returns 0xA5ADBEEF.
- Half read at 0x012 after the above → 0x0000A5AD; byte read at 0x011 → 0x000000BE.
- Half request at 0x021 and size=3 request → rsp_err=1, rdata=0, csb0 held 1 during both, responses in order.
- rsp_ready=0, issue 6 back-to-back reads → exactly 4 accepted, then req_ready=0; release rsp_ready → all 6 responses return in order with correct data.
- rst_n pulsed low while 3 requests in flight → csb0=1 and rsp_valid=0 immediately; after release, req_ready=1 and no stale responses appear.

Source files
------------

// File: rtl/sram_port0_ctrl.sv
// Valid/ready front-end for the RW port (port 0) of a 32x256 1RW1R OpenRAM macro.
// Registered macro pins, a two-edge access pipeline and an in-order, credit-limited response FIFO.
module sram_port0_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CW = $clog2(RESP_DEPTH + 3);

   function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return off != 2'd0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [NUM_WMASKS-1:0] wmask_of(input logic [1:0] size, input logic [1:0] off);
      logic [NUM_WMASKS-1:0] m;
      m = '0;
      case (size)
         2'd0: m[off] = 1'b1;
         2'd1: begin
            m[{off[1], 1'b0}] = 1'b1;
            m[{off[1], 1'b1}] = 1'b1;
         end
         default: m = '1;
      endcase
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] din_of(input logic [1:0] size, input logic [DATA_WIDTH-1:0] wdata);
      case (size)
         2'd0:    return {4{wdata[7:0]}};
         2'd1:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                                         input logic [DATA_WIDTH-1:0] dout);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      case (size)
         2'd0:    r[7:0]  = dout[{off, 3'b000} +: 8];
         2'd1:    r[15:0] = dout[{off[1], 4'b0000} +: 16];
         default: r       = dout;
      endcase
      return r;
   endfunction

   logic                  vld_p1_q, we_p1_q, err_p1_q;
   logic [1:0]            size_p1_q, off_p1_q;
   logic                  vld_p2_q, we_p2_q, err_p2_q;
   logic [1:0]            size_p2_q, off_p2_q;
   logic [CW-1:0]         cnt_q, cnt_d, inflight;
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [DATA_WIDTH:0]   mem_q [RESP_DEPTH];
   logic                  accept, acc_err, issue, issue_wr, push, pop;
   logic [DATA_WIDTH-1:0] cap_data;

   // Credits are counted from registers only, so a pop in this cycle frees nothing until next cycle.
   assign inflight  = CW'(vld_p1_q) + CW'(vld_p2_q) + cnt_q;
   assign req_ready = inflight < CW'(RESP_DEPTH);
   assign accept    = req_valid && req_ready;
   assign acc_err   = is_err(req_size, req_addr[1:0]);
   assign issue     = accept && !acc_err;
   assign issue_wr  = issue && req_we;

   assign push      = vld_p2_q;
   assign rsp_valid = cnt_q != '0;
   assign pop       = rsp_valid && rsp_ready;
   assign {rsp_err, rsp_rdata} = mem_q[rd_q];
   assign cap_data  = (we_p2_q || err_p2_q) ? '0 : lane_extract(size_p2_q, off_p2_q, sram_dout0);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push) wr_d = (wr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_d = (rd_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_q + 1'b1;
   end

   // Stage 1: macro pins are valid for exactly the cycle after the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         vld_p1_q    <= 1'b0;
         we_p1_q     <= 1'b0;
         err_p1_q    <= 1'b0;
         size_p1_q   <= '0;
         off_p1_q    <= '0;
      end else begin
         sram_csb0   <= !issue;
         sram_web0   <= !issue_wr;
         sram_wmask0 <= issue_wr ? wmask_of(req_size, req_addr[1:0]) : '0;
         if (issue) sram_addr0 <= req_addr[ADDR_WIDTH+1:2];
         if (issue_wr) sram_din0 <= din_of(req_size, req_wdata);
         vld_p1_q <= accept;
         if (accept) begin
            we_p1_q   <= req_we;
            err_p1_q  <= acc_err;
            size_p1_q <= req_size;
            off_p1_q  <= req_addr[1:0];
         end
      end
   end

   // Stage 2 and capture: dout0 is valid at the edge after the macro latched the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2_q  <= 1'b0;
         we_p2_q   <= 1'b0;
         err_p2_q  <= 1'b0;
         size_p2_q <= '0;
         off_p2_q  <= '0;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         vld_p2_q  <= vld_p1_q;
         we_p2_q   <= we_p1_q;
         err_p2_q  <= err_p1_q;
         size_p2_q <= size_p1_q;
         off_p2_q  <= off_p1_q;
         if (push) mem_q[wr_q] <= {err_p2_q, cap_data};
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && cnt_q == CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural macro model plus a byte-level reference memory
// that predicts every response at the moment its request is accepted.
module tb_sram_port0_ctrl;
   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [AW+1:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0 = '0;

   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;
   bit rnd_rdy = 1'b0;
   logic [7:0]  ref_b [1024];
   logic [31:0] macro_mem [256];
   logic [32:0] exp_q [$];
   logic [32:0] got_q [$];

   always #5 clk = ~clk;

   sram_port0_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   // Macro: latch pins on posedge, write or drive dout after the following negedge.
   logic m_act = 1'b0, m_wr = 1'b0;
   logic [3:0] m_mask;
   logic [AW-1:0] m_addr;
   logic [31:0] m_din;
   always @(posedge clk) begin
      m_act = !sram_csb0; m_wr = !sram_web0; m_mask = sram_wmask0;
      m_addr = sram_addr0; m_din = sram_din0;
   end
   always @(negedge clk) begin
      if (m_act && m_wr) begin
         for (int i = 0; i < 4; i++)
            if (m_mask[i]) macro_mem[m_addr][8*i +: 8] = m_din[8*i +: 8];
         sram_dout0 = $urandom;
      end else if (m_act) sram_dout0 = macro_mem[m_addr];
      else sram_dout0 = $urandom;
      m_act = 1'b0;
   end

   // Reference model: request semantics applied to a flat byte array at accept time.
   always @(negedge clk) begin : acc_mon
      int a, nb;
      logic e;
      logic [31:0] v;
      if (rst_n && req_valid && req_ready) begin
         a  = int'(req_addr);
         nb = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
         e  = (req_size == 2'd3) || (a % nb != 0);
         v  = '0;
         if (!e)
            for (int i = 0; i < nb; i++)
               if (req_we) ref_b[a+i] = req_wdata[8*i +: 8];
               else v[8*i +: 8] = ref_b[a+i];
         exp_q.push_back({e, v});
         acc_cnt++;
      end
      if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_rdata});
   end

   always @(posedge clk) if (rnd_rdy) begin #1; rsp_ready = ($urandom_range(0, 3) != 0); end

   task automatic send(input bit we, input logic [1:0] size, input logic [AW+1:0] addr,
                       input logic [31:0] wdata, output bit acc);
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic drain(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(posedge clk); #1;
         ok = (got_q.size() >= n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({sram_csb0, sram_web0, sram_wmask0} !== 6'b110000) begin
         errors++; $display("FAIL reset_pins got=%b want=110000", {sram_csb0, sram_web0, sram_wmask0});
      end
      checks++;
      if (sram_addr0 !== '0 || sram_din0 !== '0) begin
         errors++; $display("FAIL reset_addr_din got addr=%h din=%h want 0", sram_addr0, sram_din0);
      end
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
         errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_word_rw();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      rsp_ready = 1'b1;
      send(1'b1, 2'd2, 10'h010, 32'hDEADBEEF, acc); all_acc &= acc; idle();
      checks++;
      if ({sram_csb0, sram_web0, sram_wmask0} !== 6'b001111 || sram_addr0 !== 8'h04 || sram_din0 !== 32'hDEADBEEF) begin
         errors++; $display("FAIL word_wr_pins got=%b addr=%h din=%h want=001111 addr=04 din=deadbeef",
                            {sram_csb0, sram_web0, sram_wmask0}, sram_addr0, sram_din0);
      end
      @(posedge clk); #1;
      checks++;
      if ({sram_csb0, sram_web0, sram_wmask0} !== 6'b110000) begin
         errors++; $display("FAIL word_wr_hold got=%b want=110000", {sram_csb0, sram_web0, sram_wmask0});
      end
      repeat (5) @(posedge clk);
      #1;
      send(1'b0, 2'd2, 10'h010, 32'h0, acc); all_acc &= acc; idle();
      checks++;
      if ({sram_csb0, sram_web0, sram_wmask0, rsp_valid} !== 7'b0100000) begin
         errors++; $display("FAIL word_rd_pins got=%b want=0100000", {sram_csb0, sram_web0, sram_wmask0, rsp_valid});
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL word_rd_early got=%b want=0", rsp_valid); end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         errors++; $display("FAIL word_rd_latency got v=%b e=%b d=%h want v=1 e=0 d=deadbeef", rsp_valid, rsp_err, rsp_rdata);
      end
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL word_count got=%0d want=%0d acc=%b", got_q.size(), exp_q.size(), all_acc);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL word_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_byte_lanes();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      send(1'b1, 2'd0, 10'h013, 32'h123456A5, acc); all_acc &= acc;
      checks++;
      if (sram_wmask0 !== 4'b1000 || sram_din0 !== 32'hA5A5A5A5 || sram_web0 !== 1'b0) begin
         errors++; $display("FAIL byte_wr_pins got mask=%b din=%h web=%b want 1000 a5a5a5a5 0", sram_wmask0, sram_din0, sram_web0);
      end
      send(1'b0, 2'd2, 10'h010, 32'h0, acc); all_acc &= acc;
      send(1'b0, 2'd1, 10'h012, 32'h0, acc); all_acc &= acc;
      send(1'b0, 2'd0, 10'h011, 32'h0, acc); all_acc &= acc;
      send(1'b1, 2'd1, 10'h01A, 32'hFFFF1234, acc); all_acc &= acc;
      checks++;
      if (sram_wmask0 !== 4'b1100 || sram_din0 !== 32'h12341234 || sram_addr0 !== 8'h06) begin
         errors++; $display("FAIL half_wr_pins got mask=%b din=%h addr=%h want 1100 12341234 06", sram_wmask0, sram_din0, sram_addr0);
      end
      send(1'b0, 2'd2, 10'h018, 32'h0, acc); all_acc &= acc; idle();
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL lanes_count got=%0d want=%0d acc=%b", got_q.size(), exp_q.size(), all_acc);
      end
      if (got_q.size() >= 4) begin
         checks++;
         if (got_q[1] !== {1'b0, 32'hA5ADBEEF} || got_q[2] !== {1'b0, 32'h0000A5AD} || got_q[3] !== {1'b0, 32'h000000BE}) begin
            errors++; $display("FAIL lanes_const got %h %h %h want a5adbeef 0000a5ad 000000be", got_q[1][31:0], got_q[2][31:0], got_q[3][31:0]);
         end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL lanes_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_errors();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      logic [3:0] csb_seen;
      send(1'b0, 2'd1, 10'h021, 32'h0, acc); all_acc &= acc; csb_seen[0] = sram_csb0;
      send(1'b1, 2'd3, 10'h040, 32'hFFFFFFFF, acc); all_acc &= acc; csb_seen[1] = sram_csb0;
      send(1'b0, 2'd2, 10'h010, 32'h0, acc); all_acc &= acc; csb_seen[2] = sram_csb0;
      send(1'b1, 2'd2, 10'h022, 32'h55555555, acc); all_acc &= acc; csb_seen[3] = sram_csb0; idle();
      checks++;
      if (csb_seen !== 4'b1011) begin errors++; $display("FAIL err_csb got=%b want=1011", csb_seen); end
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL err_count got=%0d want=%0d acc=%b", got_q.size(), exp_q.size(), all_acc);
      end
      if (got_q.size() >= 2) begin
         checks++;
         if (got_q[0] !== {1'b1, 32'h0} || got_q[1] !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL err_const got %h %h want 100000000 100000000", got_q[0], got_q[1]);
         end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL err_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      int start;
      rsp_ready = 1'b0;
      start = acc_cnt;
      for (int k = 0; k < 4; k++) begin
         send(1'b0, 2'd2, 10'(32'h100 + 4*k), 32'h0, acc); all_acc &= acc;
      end
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 10'h110;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (acc_cnt - start != 4 || req_ready !== 1'b0) begin
         errors++; $display("FAIL bp_credit got accepted=%0d ready=%b want 4 0", acc_cnt - start, req_ready);
      end
      rsp_ready = 1'b1;
      send(1'b0, 2'd2, 10'h110, 32'h0, acc); all_acc &= acc;
      send(1'b0, 2'd2, 10'h114, 32'h0, acc); all_acc &= acc; idle();
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != 6 || exp_q.size() != 6) begin
         errors++; $display("FAIL bp_count got=%0d want=6 acc=%b", got_q.size(), all_acc);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL bp_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      logic [1:0] sz;
      logic [AW+1:0] addr;
      rnd_rdy = 1'b1;
      for (int k = 0; k < 120; k++) begin
         sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = 10'($urandom_range(0, 63));
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz == 2'd2) addr[1:0] = 2'b00;
         end
         send(1'($urandom_range(0, 1)), sz, addr, $urandom, acc); all_acc &= acc;
         if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
      end
      idle(); rnd_rdy = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count got=%0d want=%0d acc=%b", got_q.size(), exp_q.size(), all_acc);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL rand_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_midflight();
      bit acc, all_acc = 1'b1, ok;
      logic [32:0] e, g;
      rsp_ready = 1'b0;
      send(1'b0, 2'd2, 10'h010, 32'h0, acc); all_acc &= acc;
      send(1'b0, 2'd2, 10'h014, 32'h0, acc); all_acc &= acc;
      send(1'b0, 2'd2, 10'h018, 32'h0, acc); all_acc &= acc; idle();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (sram_csb0 !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_async got csb=%b v=%b want 1 0", sram_csb0, rsp_valid);
      end
      exp_q.delete(); got_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", req_ready); end
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_stale got=%0d want=0", got_q.size()); end
      send(1'b0, 2'd2, 10'h014, 32'h0, acc); all_acc &= acc; idle();
      drain(exp_q.size(), ok);
      checks++;
      if (!ok || !all_acc || got_q.size() != 1 || exp_q.size() != 1) begin
         errors++; $display("FAIL rst_mid_count got=%0d want=1 acc=%b", got_q.size(), all_acc);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL rst_mid_rsp got e=%b d=%h want e=%b d=%h", g[32], g[31:0], e[32], e[31:0]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      for (int w = 0; w < 256; w++) begin
         macro_mem[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_b[4*w + b] = macro_mem[w][8*b +: 8];
      end
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_errors();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
